// File: rtl/uart_hex_parser.sv
// Command front end between the UART RX and TX FIFOs: echoes characters (CR
// expanded to CR LF) and parses two-hex-digit lines terminated by CR into a byte.
module uart_hex_parser #(
  parameter bit ECHO_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  input  logic       tx_full,
  output logic [7:0] w_data,
  output logic       wr_uart,
  output logic [7:0] value,
  output logic       value_valid,
  output logic       err
);

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  typedef enum logic [1:0] {S_IDLE, S_ECHO, S_ECHO_LF, S_PROC} state_t;

  state_t     state_q, state_d;
  logic [7:0] ch_q, ch_d;
  logic [7:0] acc_q, acc_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] value_q, value_d;
  logic [7:0] w_data_q, w_data_d;
  logic       value_valid_q, value_valid_d;
  logic       err_q, err_d;
  logic       is_hex;
  logic [3:0] nib;

  always_comb begin
    is_hex = 1'b0;
    nib    = 4'h0;
    if (ch_q >= 8'h30 && ch_q <= 8'h39) begin
      is_hex = 1'b1;
      nib    = ch_q[3:0];
    end else if ((ch_q >= 8'h41 && ch_q <= 8'h46) || (ch_q >= 8'h61 && ch_q <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so +9 maps them onto 0xA..0xF
      is_hex = 1'b1;
      nib    = ch_q[3:0] + 4'd9;
    end
  end

  always_comb begin
    state_d       = state_q;
    ch_d          = ch_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    value_d       = value_q;
    w_data_d      = w_data_q;
    value_valid_d = 1'b0;
    err_d         = 1'b0;
    rd_uart       = 1'b0;
    wr_uart       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_empty) begin
          rd_uart  = ~reset;
          ch_d     = r_data;
          // w_data is preloaded so it is already valid during the echo strobe
          w_data_d = r_data;
          state_d  = ECHO_EN ? S_ECHO : S_PROC;
        end
      end
      S_ECHO: begin
        if (!tx_full) begin
          wr_uart = ~reset;
          if (ch_q == CH_CR) begin
            w_data_d = CH_LF;
            state_d  = S_ECHO_LF;
          end else begin
            state_d = S_PROC;
          end
        end
      end
      S_ECHO_LF: begin
        if (!tx_full) begin
          wr_uart = ~reset;
          state_d = S_PROC;
        end
      end
      S_PROC: begin
        state_d = S_IDLE;
        if (is_hex) begin
          if (cnt_q == 2'd2) begin
            err_d = 1'b1;
            cnt_d = 2'd0;
          end else begin
            acc_d = {acc_q[3:0], nib};
            cnt_d = cnt_q + 2'd1;
          end
        end else if (ch_q == CH_CR) begin
          if (cnt_q == 2'd2) begin
            value_d       = acc_q;
            value_valid_d = 1'b1;
          end else if (cnt_q != 2'd0) begin
            err_d = 1'b1;
          end
          cnt_d = 2'd0;
        end else if (ch_q != CH_LF) begin
          err_d = 1'b1;
          cnt_d = 2'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ch_q          <= 8'h00;
      acc_q         <= 8'h00;
      cnt_q         <= 2'd0;
      value_q       <= 8'h00;
      w_data_q      <= 8'h00;
      value_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      ch_q          <= ch_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      value_q       <= value_d;
      w_data_q      <= w_data_d;
      value_valid_q <= value_valid_d;
      err_q         <= err_d;
    end
  end

  assign value       = value_q;
  assign value_valid = value_valid_q;
  assign err         = err_q;
  assign w_data      = w_data_q;

endmodule

// File: doc/uart_hex_parser.md
# uart_hex_parser

Command front end that sits directly downstream of the `uart` block's receive FIFO and upstream of its transmit FIFO. It pops received ASCII characters one at a time and echoes each one back to the terminal, expanding CR to CR LF. It parses lines of exactly two hex digits terminated by CR into a byte on `value`, and flags malformed input on `err`. It replaces direct board-level use of `rd_uart` and `wr_uart` in the top level.

## Interface
- `ECHO_EN`, default 1: 1 = echo every popped character to TX; 0 = skip the echo states entirely.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `rx_empty`  in  1  UART RX FIFO empty
- `r_data`  in  8  UART RX FIFO head; show-ahead, valid whenever `rx_empty`=0
- `rd_uart`  out  1  one-cycle pop strobe to the RX FIFO
- `tx_full`  in  1  UART TX FIFO full
- `w_data`  out  8  byte to the TX FIFO
- `wr_uart`  out  1  one-cycle push strobe to the TX FIFO
- `value`  out  8  last successfully parsed byte; holds until the next success
- `value_valid`  out  1  one-cycle pulse when `value` updates
- `err`  out  1  one-cycle pulse on a malformed character or line

## Operation
Internal registers:
- `ch[7:0]`: latched character
- `acc[7:0]`: nibble accumulator
- `cnt[1:0]`: digits held, 0..2

FSM states and transitions:
- `S_IDLE`: if `rx_empty`=0, assert `rd_uart`=1 (combinational, this cycle only) and latch `ch<=r_data`. Next state is `S_ECHO` if `ECHO_EN`=1, else `S_PROC`. If `rx_empty`=1, stay.
- `S_ECHO`: if `tx_full`=0, assert `wr_uart`=1 with `w_data=ch`. Next state is `S_ECHO_LF` if `ch`=0x0D, else `S_PROC`. If `tx_full`=1, stay with `wr_uart`=0.
- `S_ECHO_LF`: if `tx_full`=0, assert `wr_uart`=1 with `w_data`=0x0A, then go to `S_PROC`. Otherwise stay.
- `S_PROC`: classify `ch`, update the registers as below, then return to `S_IDLE`.

`S_PROC` classification rules:
- Hex digit (0x30–0x39, 0x41–0x46, 0x61–0x66) with `cnt`<2: `acc<={acc[3:0],nib}`, `cnt<=cnt+1`.
- Hex digit with `cnt`=2 (overflow): `err` pulse, `cnt<=0`.
- CR with `cnt`=2: `value<=acc`, `value_valid` pulse, `cnt<=0`.
- CR with `cnt`=0: empty line. No pulse, no error.
- CR with `cnt`=1: `err` pulse, `cnt<=0`.
- LF (0x0A): ignored, no state change.
- Any other byte: `err` pulse, `cnt<=0`.

Output and handshake rules:
- `acc` is not cleared on error. Only `cnt` gates its use.
- Outputs and FIFO handshakes are never asserted outside the states listed above.
- `rd_uart` is asserted only in `S_IDLE`, so each character is popped exactly once.
- No pop occurs while an echo is pending.
- `value`, `value_valid`, `err` and `w_data` are registered.
- `rd_uart` and `wr_uart` are decoded from state plus `rx_empty`/`tx_full`, and are forced to 0 while `reset`=1.

## Timing
Reset (asynchronous, active-high) values:
- state = `S_IDLE`
- `ch`, `acc`, `cnt`, `value`, `w_data` = 0
- `value_valid`, `err`, `rd_uart`, `wr_uart` = 0

Cycle-level behaviour:
- Throughput with `tx_full`=0 and `ECHO_EN`=1: 3 cycles per ordinary character, 4 cycles for CR.
- Throughput with `ECHO_EN`=0: 2 cycles per character.
- `value_valid` and `err` are high for exactly the one cycle following `S_PROC`, which is the first `S_IDLE` cycle. They are never high together.
- Latency from the CR pop strobe to `value_valid`: 4 clocks with echo, 2 clocks without.
- `tx_full` stalls in `S_ECHO`/`S_ECHO_LF` are unbounded. RX bytes accumulate in the UART FIFO during a stall and none are dropped by this block.
- `rx_empty` is sampled only in `S_IDLE`.
- Reset asserted mid-line discards the partial line: `cnt`=0. A pending echo is abandoned.

## Test plan
- Send "3A\r" with `tx_full`=0 → TX sees 0x33, 0x41, 0x0D, 0x0A in order; single `value_valid` pulse with `value`=0x3A; `err` never high.
- Send "ff\r" then "0c\r" → `value`=0xFF, then `value`=0x0C; exactly two `value_valid` pulses; lowercase is accepted.
- Send "1G7\r" → `err` pulse on 'G', second `err` pulse on CR (`cnt`=1); `value` holds its previous value; all four characters are echoed.
- Send "123\r" then "\r" → `err` on '3'; both CRs produce neither `err` nor `value_valid`.
- Hold `tx_full`=1 for 10 cycles while in `S_ECHO` with 2 more bytes in the RX FIFO → `rd_uart` stays 0 and `wr_uart` stays 0 during the stall. After release, both bytes are echoed and parsed in order, with one pop each.
- Apply reset for 1 cycle after '4' has been processed, then send "5\r" → all outputs return to 0 on reset; CR arrives with `cnt`=1, giving an `err` pulse and no `value_valid`.
